// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: FSM encoding, opcode constants,
// the NOP word and the default reset vector.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous reset to RESET_PC, load has priority over
// increment, increment wraps modulo 2^32.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        incr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a single held
// instruction for the decoder, and redirect handling including drain of a
// request whose result must be thrown away.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        pc_incr;
    logic        latch_instr;
    logic        consume;
    logic        pend_wr;
    logic [31:0] pending_target;
    logic [31:0] target_aligned;

    assign target_aligned = align_word(redirect_target);

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_value(pc_load_value),
        .incr      (pc_incr),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Acks only matter in request states, so imem_ack is never looked at in S_VALID.
    always_comb begin
        state_next    = state;
        pc_load       = 1'b0;
        pc_load_value = target_aligned;
        pc_incr       = 1'b0;
        latch_instr   = 1'b0;
        consume       = 1'b0;
        pend_wr       = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                    end else begin
                        latch_instr = 1'b1;
                        state_next  = S_VALID;
                    end
                end else if (redirect_valid) begin
                    pend_wr    = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_VALID: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    pc_incr    = 1'b1;
                    consume    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pend_wr = 1'b1;
                end
                if (imem_ack) begin
                    pc_load       = 1'b1;
                    pc_load_value = redirect_valid ? target_aligned : pending_target;
                    state_next    = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr          <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            instr_pc_plus4 <= RESET_PC + 32'd4;
            fetch_count    <= '0;
            misalign_err   <= 1'b0;
            pending_target <= '0;
        end else begin
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
            if (latch_instr) begin
                instr          <= imem_rdata;
                instr_pc       <= pc;
                instr_pc_plus4 <= pc_plus4;
            end
            if (consume) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (pend_wr) begin
                pending_target <= target_aligned;
            end
        end
    end

    assign imem_req    = !reset && (state == S_FETCH || state == S_DRAIN);
    assign imem_addr   = pc;
    assign instr_valid = !reset && (state == S_VALID);
    assign opcode      = instr[6:0];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; it SHALL be word-aligned.
REQ-002 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-004 Port imem_req, output, 1, is the instruction-memory request.
REQ-005 Port imem_addr, output, 32, is the fetch address, word-aligned.
REQ-006 Port imem_ack, input, 1, means imem_rdata is valid this cycle for the request in flight.
REQ-007 Port imem_rdata, input, 32, is the fetched instruction word.
REQ-008 Port redirect_valid, input, 1, is the taken branch/jump indication from the datapath.
REQ-009 Port redirect_target, input, 32, is the branch/jump target address.
REQ-010 Port stall, input, 1, means downstream is not accepting the held instruction.
REQ-011 Port instr_valid, output, 1, means instr, instr_pc and instr_pc_plus4 are valid for the decoder.
REQ-012 Port instr, output, 32, is the held instruction word.
REQ-013 Port opcode, output, 7, SHALL equal instr[6:0] and feeds the main decoder.
REQ-014 Port instr_pc, output, 32, is the address of instr.
REQ-015 Port instr_pc_plus4, output, 32, is instr_pc+4, used for jal link.
REQ-016 Port misalign_err, output, 1, is a one-cycle pulse for a redirect target with [1:0]!=0.
REQ-017 Port fetch_count, output, 32, counts instructions consumed.

Function
REQ-018 The FSM SHALL have states S_FETCH (request outstanding), S_VALID (instruction held) and S_DRAIN (request outstanding, result to be discarded).
REQ-019 imem_req SHALL be 1 exactly in S_FETCH/S_DRAIN with reset low; imem_addr and imem_req SHALL stay stable until imem_ack is sampled.
REQ-020 imem_ack SHALL be ignored when imem_req=0.
REQ-021 S_FETCH, ack, no redirect: SHALL latch instr<=imem_rdata, instr_pc<=pc, instr_pc_plus4<=pc+4, and set instr_valid=1 from the next cycle; go to S_VALID.
REQ-022 S_VALID, stall=0, no redirect: SHALL make pc<=pc+4, fetch_count+=1, instr_valid<=0; go to S_FETCH.
REQ-023 S_VALID, stall=1: SHALL hold all outputs unchanged.
REQ-024 Redirect in S_VALID: SHALL discard the held instruction (no count), pc<=target, instr_valid<=0; go to S_FETCH.
REQ-025 Redirect in S_FETCH with ack in the same cycle: SHALL discard the returned data, pc<=target, and stay in S_FETCH so the new request issues next cycle.
REQ-026 Redirect in S_FETCH without ack: SHALL store the target as pending; go to S_DRAIN.
REQ-027 S_DRAIN: on ack, SHALL discard the data and load pc<=pending target; go to S_FETCH.
REQ-028 A redirect in S_DRAIN SHALL overwrite the pending target (latest wins).
REQ-029 Redirect SHALL take priority over stall.
REQ-030 A misaligned target SHALL pulse misalign_err for one cycle and be loaded with bits [1:0] forced to 00.
REQ-031 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count SHALL also wrap.
REQ-032 Minimum throughput is one instruction per two cycles with zero-latency ack (ack in the cycle of the request).

Reset
REQ-033 While reset=1, the block SHALL hold: state=S_FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4, fetch_count=0, misalign_err=0, pending target cleared.
REQ-034 Reset asserted mid-request SHALL abandon the request; the first request after reset deassertion SHALL be at RESET_PC in the first cycle reset is low.

Structure
REQ-035 A shared package riscv_pkg SHALL hold the state encoding, the opcode constants, NOP_INSTR=32'h0000_0013 and the RESET_PC default.
REQ-036 A single sub-module, pc_register (load/increment/hold of pc with wrap), SHALL be used; the FSM and output holding register SHALL be in instr_fetch_unit.

Verification
REQ-037 Reset release, ack 0-cycle, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8, instr_valid every other cycle, fetch_count=3 after three consumes.
REQ-038 instr held with stall=1 for 5 cycles -> instr/instr_pc unchanged, no new imem_req, fetch_count unchanged.
REQ-039 Redirect to 0x100 while a request to 0x8 waits 3 cycles for ack -> S_DRAIN, 0x8 data never valid, next imem_addr=0x100.
REQ-040 Two redirects (0x200 then 0x300) during one drain -> next fetch at 0x300 only.
REQ-041 Redirect to 0x102 -> misalign_err one-cycle pulse, next fetch at 0x100; pc 0xFFFF_FFFC consumed -> next fetch at 0x0.
REQ-042 Reset asserted mid-request with ack arriving during reset -> imem_req=0, instr_valid=0, first post-reset fetch at RESET_PC.
